// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the 2DECA5 sequencer and decoder.
// Holds the sequencer state encoding, one-hot Q phase constants,
// the stp opcode and the condition-code field values.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC1 = 3'd1,
        ST_EXEC2 = 3'd2,
        ST_HALT  = 3'd3,
        ST_PAUSE = 3'd4
    } seq_state_e;

    localparam logic [2:0] Q_FETCH = 3'b100;
    localparam logic [2:0] Q_EXEC1 = 3'b001;
    localparam logic [2:0] Q_EXEC2 = 3'b010;
    localparam logic [2:0] Q_IDLE  = 3'b000;

    localparam logic [3:0] OP_STP = 4'b0111;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_MI     = 2'b01;
    localparam logic [1:0] COND_EQ     = 2'b10;
    localparam logic [1:0] COND_NEVER  = 2'b11;

endpackage

// File: rtl/cpu_cond_eval.sv
// cpu_cond_eval: combinational condition evaluator.
// Ports:
//   cond  in  2  condition field (always / MI / EQ / never)
//   mi    in  1  negative flag
//   eq    in  1  zero flag
//   pass  out 1  1 when the instruction should take effect
module cpu_cond_eval
    import cpu_pkg::*;
(
    input  logic [1:0] cond,
    input  logic       mi,
    input  logic       eq,
    output logic       pass
);

    // Decode the condition field against the current flags.
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_ALWAYS: pass = 1'b1;
            COND_MI:     pass = mi;
            COND_EQ:     pass = eq;
            COND_NEVER:  pass = 1'b0;
            default:     pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: instruction-cycle sequencer for the 2DECA5 CPU.
// Produces the one-hot phase vector Q and the skip flip-flop, and handles
// halt (stp opcode), resume and single-step pausing. All outputs registered.
// Optional feature macro: CPU_SEQ_EXEC2_EN builds the EXEC2 phase; without
// it every instruction retires from EXEC1 and Q[1] is never set.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   C[3:0]                opcode (valid in EXEC1/EXEC2)
//   cond[1:0], MI, EQ     condition field and flags, sampled in FETCH
//   resume                pulse, leaves HALT or PAUSE
//   step_mode             level, pause after each retired instruction
//   step_req              pulse, leaves PAUSE with an ack
//   Q[2:0]                phase: 100 FETCH, 001 EXEC1, 010 EXEC2, 000 HALT/PAUSE
//   skipff                current instruction is condition-failed
//   halted, paused        state flags
//   step_ack              one-cycle ack of an accepted step_req
//   instr_count[CNT_W-1:0] retired-instruction counter (wrapping)
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int          CNT_W      = 16,
    parameter logic [15:0] EXEC2_MASK = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       C,
    input  logic [1:0]       cond,
    input  logic             MI,
    input  logic             EQ,
    input  logic             resume,
    input  logic             step_mode,
    input  logic             step_req,
    output logic [2:0]       Q,
    output logic             skipff,
    output logic             halted,
    output logic             paused,
    output logic             step_ack,
    output logic [CNT_W-1:0] instr_count
);

`ifdef CPU_SEQ_EXEC2_EN
    localparam logic EXEC2_BUILT = 1'b1;
`else
    localparam logic EXEC2_BUILT = 1'b0;
`endif

    seq_state_e state_r;
    logic       cond_pass_s;
    logic       is_stp_s;
    logic       exec2_sel_s;

    cpu_cond_eval u_cond_eval (
        .cond (cond),
        .mi   (MI),
        .eq   (EQ),
        .pass (cond_pass_s)
    );

    assign is_stp_s = (C == OP_STP);
    // Constant 0 when EXEC2 is not built, so the EXEC2 path folds away.
    assign exec2_sel_s = EXEC2_BUILT & EXEC2_MASK[C];

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FETCH;
            Q           <= Q_FETCH;
            skipff      <= 1'b0;
            halted      <= 1'b0;
            paused      <= 1'b0;
            step_ack    <= 1'b0;
            instr_count <= '0;
        end else begin
            step_ack <= 1'b0;
            case (state_r)
                ST_FETCH: begin
                    state_r <= ST_EXEC1;
                    Q       <= Q_EXEC1;
                    skipff  <= ~cond_pass_s;
                end
                ST_EXEC1: begin
                    if (is_stp_s && !skipff) begin
                        // A live stp counts as retired when it halts.
                        state_r     <= ST_HALT;
                        Q           <= Q_IDLE;
                        halted      <= 1'b1;
                        skipff      <= 1'b0;
                        instr_count <= instr_count + CNT_W'(1);
                    end else if (exec2_sel_s) begin
                        state_r <= ST_EXEC2;
                        Q       <= Q_EXEC2;
                    end else begin
                        skipff      <= 1'b0;
                        instr_count <= instr_count + CNT_W'(1);
                        if (step_mode) begin
                            state_r <= ST_PAUSE;
                            Q       <= Q_IDLE;
                            paused  <= 1'b1;
                        end else begin
                            state_r <= ST_FETCH;
                            Q       <= Q_FETCH;
                        end
                    end
                end
`ifdef CPU_SEQ_EXEC2_EN
                ST_EXEC2: begin
                    skipff      <= 1'b0;
                    instr_count <= instr_count + CNT_W'(1);
                    if (step_mode) begin
                        state_r <= ST_PAUSE;
                        Q       <= Q_IDLE;
                        paused  <= 1'b1;
                    end else begin
                        state_r <= ST_FETCH;
                        Q       <= Q_FETCH;
                    end
                end
`endif
                ST_HALT: begin
                    // step_req and step_mode have no effect while halted.
                    if (resume) begin
                        state_r <= ST_FETCH;
                        Q       <= Q_FETCH;
                        halted  <= 1'b0;
                    end else begin
                        state_r <= ST_HALT;
                    end
                end
                ST_PAUSE: begin
                    // Stays paused even if step_mode drops; only a pulse exits.
                    if (step_req || resume) begin
                        state_r  <= ST_FETCH;
                        Q        <= Q_FETCH;
                        paused   <= 1'b0;
                        step_ack <= step_req;
                    end else begin
                        state_r <= ST_PAUSE;
                    end
                end
                default: begin
                    state_r <= ST_FETCH;
                    Q       <= Q_FETCH;
                    skipff  <= 1'b0;
                    halted  <= 1'b0;
                    paused  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed scoreboard bench for cpu_sequencer.
// Expected output words are queued as each step is driven and compared
// one cycle later, #1 after the rising edge.
module tb_cpu_sequencer;

    localparam int CW = 10;

    logic          clk;
    logic          rst_n;
    logic [3:0]    c;
    logic [1:0]    cond;
    logic          mi;
    logic          eq;
    logic          resume;
    logic          step_mode;
    logic          step_req;
    logic [2:0]    q;
    logic          skipff;
    logic          halted;
    logic          paused;
    logic          step_ack;
    logic [CW-1:0] instr_count;

    int compared = 0;
    int mismatched = 0;
    logic [CW-1:0] exp_cnt;

    logic [CW+6:0] exp_q[$];
    string         tag_q[$];

    cpu_sequencer #(.CNT_W(CW), .EXEC2_MASK(16'h0200)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .C           (c),
        .cond        (cond),
        .MI          (mi),
        .EQ          (eq),
        .resume      (resume),
        .step_mode   (step_mode),
        .step_req    (step_req),
        .Q           (q),
        .skipff      (skipff),
        .halted      (halted),
        .paused      (paused),
        .step_ack    (step_ack),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop the oldest expectation and compare it with the current outputs.
    task automatic compare_head();
        logic [CW+6:0] obs;
        logic [CW+6:0] exp;
        string tag;
        obs = {q, skipff, halted, paused, step_ack, instr_count};
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed Q/skip/halt/pause/ack/cnt=%b_%b%b%b%b_%h expected %b_%b%b%b%b_%h",
                   tag, obs[CW+6:CW+4], obs[CW+3], obs[CW+2], obs[CW+1], obs[CW], obs[CW-1:0],
                   exp[CW+6:CW+4], exp[CW+3], exp[CW+2], exp[CW+1], exp[CW], exp[CW-1:0]);
        end
    endtask

    // Queue the expectation for the next edge, clock once, then check it.
    task automatic step(input string tag, input logic [2:0] eq_q, input logic e_sk,
                        input logic e_h, input logic e_p, input logic e_a);
        exp_q.push_back({eq_q, e_sk, e_h, e_p, e_a, exp_cnt});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    // Check the outputs immediately, without a clock edge.
    task automatic check_now(input string tag, input logic [2:0] eq_q, input logic e_sk,
                             input logic e_h, input logic e_p, input logic e_a);
        exp_q.push_back({eq_q, e_sk, e_h, e_p, e_a, exp_cnt});
        tag_q.push_back(tag);
        compare_head();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1; c = 4'd0; cond = 2'b00; mi = 1'b0; eq = 1'b0;
        resume = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        exp_cnt = '0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_now("reset", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // 1: single-cycle instructions
        step("t1_exec1a", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cnt = 10'd1;
        step("t1_fetchb", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t1_exec1b", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cnt = 10'd2;
        step("t1_fetchc", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);

        // 2: opcode 9 is in EXEC2_MASK
        c = 4'b1001;
        step("t2_exec1", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CPU_SEQ_EXEC2_EN
        step("t2_exec2", 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        exp_cnt = 10'd3;
        step("t2_fetch", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: condition evaluation into skipff
        c = 4'd0; cond = 2'b01; mi = 1'b0;
        step("t3_mi0_skip", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        cond = 2'b00;
        exp_cnt = 10'd4;
        step("t3_skip_clr", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        cond = 2'b01; mi = 1'b1;
        step("t3_mi1_noskip", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cnt = 10'd5;
        step("t3_fetch", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        cond = 2'b10; eq = 1'b0; mi = 1'b0;
        step("t3_eq0_skip", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_cnt = 10'd6;
        step("t3_fetch2", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);

        // 4: stp halts, skipped stp retires
        c = 4'b0111; cond = 2'b00;
        step("t4_stp_exec1", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cnt = 10'd7;
        step("t4_halt", 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        step_req = 1'b1; step_mode = 1'b1;
        step("t4_halt_ign_step", 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        step_req = 1'b0; step_mode = 1'b0; resume = 1'b1;
        step("t4_resume", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        resume = 1'b0; cond = 2'b11;
        step("t4_skipstp_exec1", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_cnt = 10'd8;
        step("t4_skipstp_ret", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        cond = 2'b00;
        step("t4_stp2_exec1", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cnt = 10'd9;
        step("t4_halt2", 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        resume = 1'b1;
        step("t4_resume_first", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        resume = 1'b0;

        // 5: single-step mode
        c = 4'd0; step_mode = 1'b1; step_req = 1'b1;
        step("t5_req_in_fetch", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        step_req = 1'b0;
        exp_cnt = 10'd10;
        step("t5_pause", 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        step_mode = 1'b0;
        step("t5_pause_hold", 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        step_req = 1'b1;
        step("t5_step_ack", 3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
        step_req = 1'b0;
        step("t5_ack_drop", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cnt = 10'd11;
        step("t5_free_run", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        step_mode = 1'b1;
        step("t5_exec1b", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cnt = 10'd12;
        step("t5_pause2", 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        step_req = 1'b1; resume = 1'b1;
        step("t5_both_ack", 3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
        step_req = 1'b0; resume = 1'b0;
        step("t5_exec1c", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cnt = 10'd13;
        step("t5_pause3", 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        resume = 1'b1; step_mode = 1'b0;
        step("t5_resume_noack", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        resume = 1'b0;

        // 6: counter wrap (1023 - 13 = 1010 more instructions)
        repeat (2 * 1010) @(posedge clk);
        #1;
        exp_cnt = 10'h3FF;
        check_now("t6_count_max", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t6_exec1", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cnt = 10'h000;
        step("t6_wrap", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t6_exec1b", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cnt = 10'h001;
        step("t6_count1", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);

        // 6b: reset in the middle of an instruction
        c = 4'b1001; cond = 2'b11;
        step("t6_mid_exec1", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef CPU_SEQ_EXEC2_EN
        step("t6_mid_exec2", 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        check_now("t6_async_reset", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; c = 4'd0; cond = 2'b00;
        step("t6_after_reset", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cnt = 10'd1;
        step("t6_after_retire", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction-cycle sequencer for the 2DECA5 CPU. It generates the one-hot phase vector `Q[2:0]` and the skip flip-flop consumed by the control decoder, and it owns halt, resume and single-step handling. It sits between the instruction register/flags and the control decoder. It replaces the free-running phase ring with a state machine that can stretch instructions to EXEC2 and stop on `stp`.

## Interface
Parameters:
- `CNT_W`, 16, width of the retired-instruction counter.
- `EXEC2_MASK`, 16'h0000, bit n set means opcode n takes EXEC2 after EXEC1.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `C`  in  4  opcode from the instruction register. Valid in EXEC1 and EXEC2.
- `cond`  in  2  condition field. Sampled in FETCH: 00 always, 01 if MI, 10 if EQ, 11 never.
- `MI`  in  1  negative flag.
- `EQ`  in  1  zero flag.
- `resume`  in  1  one-cycle pulse that leaves HALT.
- `step_mode`  in  1  level; 1 means pause after every retired instruction.
- `step_req`  in  1  one-cycle pulse that leaves PAUSE.
- `Q`  out  3  phase: 100 FETCH, 001 EXEC1, 010 EXEC2, 000 HALT/PAUSE.
- `skipff`  out  1  current instruction is condition-failed; suppresses its side effects.
- `halted`  out  1  state is HALT.
- `paused`  out  1  state is PAUSE.
- `step_ack`  out  1  one-cycle pulse confirming an accepted `step_req`.
- `instr_count`  out  CNT_W  number of retired instructions, wraps modulo 2^CNT_W.

## Operation
States: FETCH, EXEC1, EXEC2, HALT, PAUSE. All outputs are registered.

Reset values:
- `Q`=100 (FETCH).
- `skipff`=0, `halted`=0, `paused`=0, `step_ack`=0, `instr_count`=0.

Transitions, one per clock:
- FETCH -> EXEC1 always. On this edge `skipff` loads the inverse of the `cond` result: cond=00 gives 0, 01 gives ~MI, 10 gives ~EQ, 11 gives 1.
- EXEC1 branches in this priority order:
  - opcode 0111 (stp) with skipff=0 goes to HALT.
  - `EXEC2_MASK[C]`=1 goes to EXEC2.
  - otherwise the instruction retires.
- EXEC2 -> retire.
- Retire means go to PAUSE if `step_mode`=1, otherwise to FETCH.
- `instr_count` increments by 1 on every retire and on the EXEC1 -> HALT edge. 0xFFFF+1 wraps to 0.
- `skipff` holds its value through EXEC1 and EXEC2. It clears to 0 on entry to FETCH, HALT or PAUSE.
- A skipped `stp` (skipff=1) retires normally and does not halt.

HALT:
- Leaves to FETCH on `resume`=1.
- Ignores `step_req` and `step_mode`.

PAUSE:
- Leaves to FETCH on `step_req`=1 or `resume`=1. Both asserted together is one exit and one ack.
- `step_ack`=1 for exactly the cycle after the accepting edge.
- If `step_mode` is dropped while in PAUSE, the block stays in PAUSE until `step_req` or `resume`.

`resume` and `step_req` outside their waiting state are ignored and produce no ack.

## Timing
- Single-cycle instruction: 2 clocks (FETCH, EXEC1).
- EXEC2 instruction: 3 clocks.
- `Q` changes only on clock edges. Exactly one bit of `Q` is set, or none in HALT/PAUSE.
- `skipff` is valid for the whole EXEC1/EXEC2 window. It is derived from the `cond`/flags sampled during FETCH.
- Minimum HALT occupancy is 1 cycle. A `resume` sampled in the first HALT cycle exits on that edge.
- `rst_n` low in any state returns asynchronously to the reset values. A partially executed instruction is dropped and is not counted.

## Configuration
- `CPU_SEQ_EXEC2_EN` defined: EXEC2 and `EXEC2_MASK` behave as above.
- Undefined: the EXEC2 state is not built, `EXEC2_MASK` is ignored, every instruction retires from EXEC1, and `Q[1]` is constant 0.

## Structure
- Shared package `cpu_pkg` holds:
  - state encoding constants (FETCH/EXEC1/EXEC2/HALT/PAUSE);
  - `Q` one-hot constants;
  - opcode constant `OP_STP`=4'b0111;
  - condition-code constants.
- Sub-module `cpu_cond_eval` is natural: combinational `cond`, `MI`, `EQ` -> pass/fail. It is reused by the decoder later.

## Test plan
1. Reset, then release with C=0000 and cond=00 -> `Q` sequence 100, 001, 100, 001. `instr_count` is 1 after the first EXEC1 -> FETCH edge.
2. With `CPU_SEQ_EXEC2_EN` defined and EXEC2_MASK=16'h0200, C=1001 -> `Q` 100, 001, 010, 100. Undefined -> 100, 001, 100.
3. cond=01 with MI=0 in FETCH -> `skipff`=1 in EXEC1. cond=01 with MI=1 -> `skipff`=0.
4. C=0111 with skipff=0 -> `Q`=000 and `halted`=1 until `resume`, then FETCH. Same opcode with cond=11 -> no halt and `instr_count`+1.
5. step_mode=1 -> PAUSE after each instruction. `step_req` -> `step_ack` for 1 cycle and next FETCH. `step_req` while in FETCH -> no ack.
6. Preload `instr_count` to 0xFFFF via 65535 retires, then 1 more -> 0x0000. Assert `rst_n` low mid-EXEC2 -> immediate `Q`=100 and count 0.
